ps2_key_ctrl: RTL and testbench

- Sits between the PS/2 byte receiver and the CPU-side keyboard MMIO register.
- Consumes one-cycle scan-code strobes, tracks E0 (extended) and F0 (break) prefixes, and suppresses typematic repeats.
- Packs completed key events into a FIFO and presents them on a ready/valid port.
- Keeps a sticky overflow flag and a press counter for software.

---
 rtl/ps2_key_ctrl_if.sv | 19 +
 rtl/ps2_key_ctrl.sv | 138 +++++++++++++
 tb/tb_ps2_key_ctrl.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/ps2_key_ctrl_if.sv
// Ready/valid key-event stream between the keyboard controller and the CPU MMIO side.
// master = event producer (the controller), slave = event consumer.
interface ps2_key_ctrl_if;
  logic       evt_valid;
  logic       evt_ready;
  logic [7:0] evt_code;
  logic       evt_ext;
  logic       evt_make;

  modport master (
    output evt_valid, evt_code, evt_ext, evt_make,
    input  evt_ready
  );

  modport slave (
    input  evt_valid, evt_code, evt_ext, evt_make,
    output evt_ready
  );
endinterface

// File: rtl/ps2_key_ctrl.sv
// PS/2 scan-code decoder: folds E0/F0 prefixes into key events, drops typematic
// repeats of the held key, and queues events in a first-word-fall-through FIFO.
module ps2_key_ctrl #(
  parameter int FIFO_DEPTH      = 8,
  parameter int SUPPRESS_REPEAT = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 code_valid,
  input  logic [7:0]           code_data,
  input  logic                 ovf_clr,
  output logic                 overflow,
  output logic [7:0]           press_count,
  output logic                 key_held,
  ps2_key_ctrl_if.master       evt
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, EXT, BRK, EXT_BRK} state_t;

  state_t          state_q, state_d;
  logic [8:0]      held_q, held_d;
  logic            key_held_q, key_held_d;
  logic [7:0]      press_count_q, press_count_d;
  logic            overflow_q, overflow_d;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [AW:0]     count_q, count_d;
  logic [9:0]      mem_q [FIFO_DEPTH];

  logic            filtered, emit, emit_ext, emit_make;
  logic            is_match, is_repeat, push_req, pop, full, push_ok, drop;

  always_comb begin
    state_d   = state_q;
    emit      = 1'b0;
    emit_ext  = 1'b0;
    emit_make = 1'b0;
    filtered  = (code_data == 8'h00) || (code_data == 8'hFF) || (code_data == 8'hFA) ||
                (code_data == 8'hAA) || (code_data == 8'hEE);
    if (code_valid && !filtered) begin
      case (state_q)
        IDLE: begin
          if (code_data == 8'hE0)      state_d = EXT;
          else if (code_data == 8'hF0) state_d = BRK;
          else begin emit = 1'b1; emit_make = 1'b1; end
        end
        EXT: begin
          if (code_data == 8'hF0)      state_d = EXT_BRK;
          else if (code_data != 8'hE0) begin
            emit = 1'b1; emit_make = 1'b1; emit_ext = 1'b1; state_d = IDLE;
          end
        end
        BRK: begin
          if (code_data == 8'hE0)      state_d = EXT_BRK;
          else if (code_data != 8'hF0) begin emit = 1'b1; state_d = IDLE; end
        end
        default: begin
          if (code_data != 8'hE0 && code_data != 8'hF0) begin
            emit = 1'b1; emit_ext = 1'b1; state_d = IDLE;
          end
        end
      endcase
    end
  end

  // A full FIFO still accepts a push when the head leaves in the same cycle.
  always_comb begin
    is_match  = key_held_q && ({emit_ext, code_data} == held_q);
    is_repeat = (SUPPRESS_REPEAT != 0) && emit && emit_make && is_match;
    push_req  = emit && !is_repeat;
    pop       = (count_q != '0) && evt.evt_ready;
    full      = (count_q == FULL_CNT);
    push_ok   = push_req && (!full || pop);
    drop      = push_req && !push_ok;

    held_d        = held_q;
    key_held_d    = key_held_q;
    press_count_d = press_count_q;
    wr_ptr_d      = wr_ptr_q;
    rd_ptr_d      = rd_ptr_q;
    count_d       = count_q;

    if (push_req && emit_make) begin
      held_d     = {emit_ext, code_data};
      key_held_d = 1'b1;
    end else if (push_req && !emit_make && is_match) begin
      key_held_d = 1'b0;
    end

    if (push_ok && emit_make) press_count_d = press_count_q + 8'd1;
    if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)     rd_ptr_d = rd_ptr_q + AW'(1);
    if (push_ok && !pop)      count_d = count_q + (AW+1)'(1);
    else if (!push_ok && pop) count_d = count_q - (AW+1)'(1);

    if (drop)         overflow_d = 1'b1;
    else if (ovf_clr) overflow_d = 1'b0;
    else              overflow_d = overflow_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      held_q        <= '0;
      key_held_q    <= 1'b0;
      press_count_q <= '0;
      overflow_q    <= 1'b0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
    end else begin
      state_q       <= state_d;
      held_q        <= held_d;
      key_held_q    <= key_held_d;
      press_count_q <= press_count_d;
      overflow_q    <= overflow_d;
      wr_ptr_q      <= wr_ptr_d;
      rd_ptr_q      <= rd_ptr_d;
      count_q       <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && push_ok) mem_q[wr_ptr_q] <= {emit_ext, emit_make, code_data};
  end

  assign evt.evt_valid = (count_q != '0);
  assign evt.evt_ext   = mem_q[rd_ptr_q][9];
  assign evt.evt_make  = mem_q[rd_ptr_q][8];
  assign evt.evt_code  = mem_q[rd_ptr_q][7:0];
  assign overflow      = overflow_q;
  assign press_count   = press_count_q;
  assign key_held      = key_held_q;

endmodule

// File: tb/tb_ps2_key_ctrl.sv
// Scoreboard bench for ps2_key_ctrl: directed scan-byte sequences push expected
// events into a queue, and a monitor checks each event the DUT hands over.
module tb_ps2_key_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic       code_valid;
  logic [7:0] code_data;
  logic       ovf_clr;
  logic       overflow;
  logic [7:0] press_count;
  logic       key_held;

  int total = 0;
  int bad   = 0;
  logic [9:0] exp_q[$];

  ps2_key_ctrl_if evt_if ();

  ps2_key_ctrl #(.FIFO_DEPTH(8), .SUPPRESS_REPEAT(1)) dut (
    .clk         (clk),
    .reset       (reset),
    .code_valid  (code_valid),
    .code_data   (code_data),
    .ovf_clr     (ovf_clr),
    .overflow    (overflow),
    .press_count (press_count),
    .key_held    (key_held),
    .evt         (evt_if.master)
  );

  always #5 clk = ~clk;

  task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0h, want %0h", name, actual, expected);
    end
  endtask

  task automatic push_expected(input logic ext, input logic make, input logic [7:0] code);
    exp_q.push_back({ext, make, code});
  endtask

  // Called just after a rising edge; leaves the strobe up for exactly one edge.
  task automatic apply_stimulus(input logic [7:0] b);
    code_valid = 1'b1;
    code_data  = b;
    @(posedge clk); #1;
    code_valid = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check_output("rst_evt_valid", evt_if.evt_valid, 0);
    check_output("rst_overflow", overflow, 0);
    check_output("rst_key_held", key_held, 0);
    check_output("rst_press_count", press_count, 0);
  endtask

  task automatic wait_drain(input string name);
    evt_if.evt_ready = 1'b1;
    for (int i = 0; i < 100 && exp_q.size() != 0; i++) @(posedge clk);
    @(posedge clk); #1;
    check_output({name, "_pending"}, exp_q.size(), 0);
    check_output({name, "_empty"}, evt_if.evt_valid, 0);
  endtask

  // Monitor: every accepted head event must match the oldest expected one.
  always @(negedge clk) begin
    if (!reset && evt_if.evt_valid && evt_if.evt_ready) begin
      if (exp_q.size() == 0) begin
        check_output("unexpected_evt", {evt_if.evt_ext, evt_if.evt_make, evt_if.evt_code}, 10'h3FF);
      end else begin
        check_output("evt", {evt_if.evt_ext, evt_if.evt_make, evt_if.evt_code}, exp_q.pop_front());
      end
    end
  end

  initial begin
    logic [7:0] fill4 [9];
    logic [7:0] fill5 [8];
    fill4 = '{8'h15, 8'h1D, 8'h24, 8'h2D, 8'h2C, 8'h35, 8'h3C, 8'h43, 8'h44};
    fill5 = '{8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E};

    reset = 1'b1; code_valid = 1'b0; code_data = 8'h00; ovf_clr = 1'b0;
    evt_if.evt_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    do_reset();

    // Plain make then break, one-cycle latency
    push_expected(0, 1, 8'h1C);
    apply_stimulus(8'h1C);
    check_output("t1_latency", evt_if.evt_valid, 1);
    check_output("t1_held_on", key_held, 1);
    push_expected(0, 0, 8'h1C);
    apply_stimulus(8'hF0);
    apply_stimulus(8'h1C);
    check_output("t1_held_off", key_held, 0);
    wait_drain("t1");
    check_output("t1_press_count", press_count, 1);

    // Extended make/break, then a plain make proves the FSM is back in IDLE
    push_expected(1, 1, 8'h75);
    push_expected(1, 0, 8'h75);
    push_expected(0, 1, 8'h1C);
    push_expected(0, 0, 8'h1C);
    apply_stimulus(8'hE0); apply_stimulus(8'h75);
    apply_stimulus(8'hE0); apply_stimulus(8'hF0); apply_stimulus(8'h75);
    apply_stimulus(8'h1C); apply_stimulus(8'hF0); apply_stimulus(8'h1C);
    wait_drain("t2");
    check_output("t2_press_count", press_count, 3);

    // Typematic repeats are dropped
    push_expected(0, 1, 8'h1C);
    push_expected(0, 0, 8'h1C);
    apply_stimulus(8'h1C); apply_stimulus(8'h1C); apply_stimulus(8'h1C);
    check_output("t3_held", key_held, 1);
    apply_stimulus(8'hF0); apply_stimulus(8'h1C);
    wait_drain("t3");
    check_output("t3_press_count", press_count, 4);

    // Overflow on the ninth make with a stalled consumer
    do_reset();
    evt_if.evt_ready = 1'b0;
    for (int i = 0; i < 9; i++) begin
      if (i < 8) push_expected(0, 1, fill4[i]);
      apply_stimulus(fill4[i]);
      if (i == 7) check_output("t4_no_ovf_at_8", overflow, 0);
    end
    check_output("t4_ovf", overflow, 1);
    check_output("t4_press_count", press_count, 8);
    wait_drain("t4");
    check_output("t4_ovf_sticky", overflow, 1);
    ovf_clr = 1'b1;
    @(posedge clk); #1;
    ovf_clr = 1'b0;
    check_output("t4_ovf_clr", overflow, 0);

    // Full FIFO: simultaneous pop and push is accepted
    evt_if.evt_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      push_expected(0, 1, fill5[i]);
      apply_stimulus(fill5[i]);
    end
    check_output("t5_full_no_ovf", overflow, 0);
    evt_if.evt_ready = 1'b1;
    push_expected(0, 1, 8'h46);
    apply_stimulus(8'h46);
    evt_if.evt_ready = 1'b0;
    check_output("t5_push_pop_ovf", overflow, 0);
    check_output("t5_valid", evt_if.evt_valid, 1);
    ovf_clr = 1'b1;
    apply_stimulus(8'h4E);
    ovf_clr = 1'b0;
    check_output("t5_still_full_set_wins", overflow, 1);
    wait_drain("t5");
    check_output("t5_press_count", press_count, 17);

    // Reset clears a pending break prefix; filtered bytes are ignored
    apply_stimulus(8'hF0);
    do_reset();
    push_expected(0, 1, 8'h1C);
    apply_stimulus(8'h1C);
    push_expected(1, 1, 8'h75);
    apply_stimulus(8'hE0); apply_stimulus(8'hFA); apply_stimulus(8'hAA);
    apply_stimulus(8'h00); apply_stimulus(8'h75);
    wait_drain("t6");
    check_output("t6_press_count", press_count, 2);

    // press_count wraps 255 -> 0
    do_reset();
    for (int i = 0; i < 256; i++) begin
      logic [7:0] c;
      c = i[0] ? 8'h1D : 8'h1C;
      push_expected(0, 1, c);
      apply_stimulus(c);
      if (i == 254) check_output("t7_count_255", press_count, 255);
    end
    check_output("t7_count_wrap", press_count, 0);
    wait_drain("t7");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
